// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The master side is the controller: it consumes decoder fields and status
// flags and drives every datapath strobe and mux select.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_ctl;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  op, funct, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, ext_zero, alu_ctl,
               reg_write, reg_dst, wb_src, halted, state
    );

    modport slave (
        output op, funct, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, ext_zero, alu_ctl,
               reg_write, reg_dst, wb_src, halted, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Each instruction walks fetch, decode and the
// execute/memory/writeback states its opcode needs; outputs are decoded from
// the current state, with mem_ready qualifying fetch strobes and memory exits.
module mips_multicycle_ctrl (
    input logic                    clk,
    input logic                    reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic       r_arith;
    logic [2:0] r_alu_ctl;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b, reg_dst, wb_src;
    logic       alu_src_a, ext_zero, reg_write, halted;
    logic [2:0] alu_ctl;

    // State register; reset always restarts at instruction fetch.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Map an R-type funct to its ALU operation and flag whether it is arithmetic.
    always_comb begin
        r_arith   = 1'b1;
        r_alu_ctl = ALU_ADD;
        case (bus.funct)
            FN_ADD:  r_alu_ctl = ALU_ADD;
            FN_SUB:  r_alu_ctl = ALU_SUB;
            FN_AND:  r_alu_ctl = ALU_AND;
            FN_OR:   r_alu_ctl = ALU_OR;
            FN_SLT:  r_alu_ctl = ALU_SLT;
            default: r_arith   = 1'b0;
        endcase
    end

    // Next-state and strobe decode; reset overrides every output to idle.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        ext_zero  = 1'b0;
        alu_ctl   = 3'b000;
        reg_write = 1'b0;
        reg_dst   = 2'd0;
        wb_src    = 2'd0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                alu_ctl   = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                alu_ctl   = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_J, OP_JAL:    state_d = S_JUMP;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI, OP_ORI: state_d = S_I_EXEC;
                    OP_RTYPE: begin
                        if (r_arith)                 state_d = S_R_EXEC;
                        else if (bus.funct == FN_JR) state_d = S_JUMP;
                        else                         state_d = S_HALT;
                    end
                    default:         state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_ctl   = ALU_ADD;
                state_d   = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wb_src    = 2'd1;
                state_d   = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctl   = r_alu_ctl;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (bus.op == OP_ORI) begin
                    alu_ctl  = ALU_OR;
                    ext_zero = 1'b1;
                end else begin
                    alu_ctl  = ALU_ADD;
                end
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = ALU_SUB;
                pc_src    = 2'd1;
                pc_write  = (bus.op == OP_BNE) ? !bus.alu_zero : bus.alu_zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                state_d  = S_FETCH;
                if (bus.op == OP_JAL) begin
                    pc_src    = 2'd2;
                    reg_write = 1'b1;
                    reg_dst   = 2'd2;
                    wb_src    = 2'd2;
                end else if (bus.op == OP_J) begin
                    pc_src = 2'd2;
                end else begin
                    pc_src = 2'd3;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            iord      = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            alu_src_a = 1'b0;
            alu_src_b = 2'd0;
            ext_zero  = 1'b0;
            alu_ctl   = 3'b000;
            reg_write = 1'b0;
            reg_dst   = 2'd0;
            wb_src    = 2'd0;
            halted    = 1'b0;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.iord      = iord;
    assign bus.ir_write  = ir_write;
    assign bus.pc_write  = pc_write;
    assign bus.pc_src    = pc_src;
    assign bus.alu_src_a = alu_src_a;
    assign bus.alu_src_b = alu_src_b;
    assign bus.ext_zero  = ext_zero;
    assign bus.alu_ctl   = alu_ctl;
    assign bus.reg_write = reg_write;
    assign bus.reg_dst   = reg_dst;
    assign bus.wb_src    = wb_src;
    assign bus.halted    = halted;
    assign bus.state     = reset ? 4'd0 : state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. Each instruction is expanded by a
// reference model into its expected per-cycle output vectors; a monitor
// compares them against the controller one cycle at a time.
module tb_mips_multicycle_ctrl;
    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_ctl;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       halted;
    } outs_t;

    localparam int K_R = 0, K_JR = 1, K_J = 2, K_JAL = 3, K_BEQ = 4, K_BNE = 5;
    localparam int K_ADDI = 6, K_ORI = 7, K_LW = 8, K_SW = 9, K_ILL = 10;
    localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000;
    localparam logic [2:0] A_OR = 3'b001, A_SLT = 3'b111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    outs_t exp_q[$];
    outs_t mon_exp;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t observe();
        outs_t a;
        a.state     = bus.state;
        a.mem_req   = bus.mem_req;
        a.mem_we    = bus.mem_we;
        a.iord      = bus.iord;
        a.ir_write  = bus.ir_write;
        a.pc_write  = bus.pc_write;
        a.pc_src    = bus.pc_src;
        a.alu_src_a = bus.alu_src_a;
        a.alu_src_b = bus.alu_src_b;
        a.ext_zero  = bus.ext_zero;
        a.alu_ctl   = bus.alu_ctl;
        a.reg_write = bus.reg_write;
        a.reg_dst   = bus.reg_dst;
        a.wb_src    = bus.wb_src;
        a.halted    = bus.halted;
        return a;
    endfunction

    task automatic checkOutput(input outs_t e);
        outs_t a;
        a = observe();
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL cycle_outputs t=%0t: got state=%0d vec=%h, want state=%0d vec=%h",
                     $time, a.state, a, e.state, e);
        end
    endtask

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            checkOutput(mon_exp);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired: got timeout, want completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                    return K_R;
                return K_ILL;
            end
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h08: return K_ADDI;
            6'h0D: return K_ORI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return A_SUB;
            6'h24:   return A_AND;
            6'h25:   return A_OR;
            6'h2A:   return A_SLT;
            default: return A_ADD;
        endcase
    endfunction

    function automatic outs_t at_state(input int st);
        outs_t e;
        e = '0;
        e.state = 4'(st);
        return e;
    endfunction

    task automatic applyStimulus(input logic [5:0] op_v, input logic [5:0] fn_v,
                                 input logic zero_v, input logic ready_v,
                                 input logic rst_v, input outs_t e);
        bus.op        = op_v;
        bus.funct     = fn_v;
        bus.alu_zero  = zero_v;
        bus.mem_ready = ready_v;
        reset         = rst_v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(rnd6(), rnd6(), rnd1(), rnd1(), 1'b1, '0);
    endtask

    // Reference model: expand one instruction into its cycle-by-cycle behaviour.
    task automatic runInstruction(input logic [5:0] op, input logic [5:0] fn,
                                  input int fetch_waits, input int mem_waits,
                                  input logic zero, input int halt_cycles,
                                  input bit abort_in_mem);
        outs_t e;
        int    kind;
        kind = classify(op, fn);
        for (int w = 0; w <= fetch_waits; w++) begin
            e = at_state(0);
            e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_ctl = A_ADD;
            if (w == fetch_waits) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
            applyStimulus(rnd6(), rnd6(), rnd1(), (w == fetch_waits), 1'b0, e);
        end
        e = at_state(1);
        e.alu_src_b = 2'd3; e.alu_ctl = A_ADD;
        applyStimulus(op, fn, rnd1(), rnd1(), 1'b0, e);
        case (kind)
            K_LW, K_SW: begin
                e = at_state(2);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_ctl = A_ADD;
                applyStimulus(op, fn, rnd1(), rnd1(), 1'b0, e);
                for (int w = 0; w <= mem_waits; w++) begin
                    e = at_state(kind == K_LW ? 3 : 5);
                    e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (kind == K_SW);
                    if (abort_in_mem && w == mem_waits) begin
                        applyStimulus(op, fn, rnd1(), 1'b0, 1'b1, '0);
                        return;
                    end
                    applyStimulus(op, fn, rnd1(), (w == mem_waits), 1'b0, e);
                end
                if (kind == K_LW) begin
                    e = at_state(4);
                    e.reg_write = 1'b1; e.wb_src = 2'd1;
                    applyStimulus(op, fn, rnd1(), rnd1(), 1'b0, e);
                end
            end
            K_R: begin
                e = at_state(6);
                e.alu_src_a = 1'b1; e.alu_ctl = r_alu(fn);
                applyStimulus(op, fn, rnd1(), rnd1(), 1'b0, e);
                e = at_state(7);
                e.reg_write = 1'b1; e.reg_dst = 2'd1;
                applyStimulus(op, fn, rnd1(), rnd1(), 1'b0, e);
            end
            K_ADDI, K_ORI: begin
                e = at_state(8);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                e.alu_ctl = (kind == K_ORI) ? A_OR : A_ADD;
                e.ext_zero = (kind == K_ORI);
                applyStimulus(op, fn, rnd1(), rnd1(), 1'b0, e);
                e = at_state(9);
                e.reg_write = 1'b1;
                applyStimulus(op, fn, rnd1(), rnd1(), 1'b0, e);
            end
            K_BEQ, K_BNE: begin
                e = at_state(10);
                e.alu_src_a = 1'b1; e.alu_ctl = A_SUB; e.pc_src = 2'd1;
                e.pc_write = (kind == K_BEQ) ? zero : !zero;
                applyStimulus(op, fn, zero, rnd1(), 1'b0, e);
            end
            K_J, K_JAL, K_JR: begin
                e = at_state(11);
                e.pc_write = 1'b1;
                e.pc_src = (kind == K_JR) ? 2'd3 : 2'd2;
                if (kind == K_JAL) begin
                    e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wb_src = 2'd2;
                end
                applyStimulus(op, fn, rnd1(), rnd1(), 1'b0, e);
            end
            default: begin
                e = at_state(15);
                e.halted = 1'b1;
                for (int i = 0; i < halt_cycles; i++)
                    applyStimulus(rnd6(), rnd6(), rnd1(), rnd1(), 1'b0, e);
                resetCycles(1);
            end
        endcase
    endtask

    // Directed scenarios first, then randomized instruction mix.
    initial begin
        logic [5:0] ops [9];
        logic [5:0] fns [6];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
        reset = 1'b1;
        bus.op = '0; bus.funct = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        resetCycles(3);
        runInstruction(6'h00, 6'h20, 0, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h23, rnd6(), 0, 2, 1'b0, 0, 1'b0);
        runInstruction(6'h04, rnd6(), 0, 0, 1'b1, 0, 1'b0);
        runInstruction(6'h04, rnd6(), 0, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h05, rnd6(), 0, 0, 1'b1, 0, 1'b0);
        runInstruction(6'h05, rnd6(), 0, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h03, rnd6(), 0, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h00, 6'h08, 0, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h3F, rnd6(), 0, 0, 1'b0, 10, 1'b0);
        runInstruction(6'h2B, rnd6(), 1, 2, 1'b0, 0, 1'b1);
        runInstruction(6'h2B, rnd6(), 2, 1, 1'b0, 0, 1'b0);
        runInstruction(6'h0D, rnd6(), 0, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h08, rnd6(), 1, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h02, rnd6(), 0, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h00, 6'h2A, 0, 0, 1'b0, 0, 1'b0);
        runInstruction(6'h00, 6'h13, 0, 0, 1'b0, 3, 1'b0);
        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 9) == 0) ? rnd6() : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 9) == 0) ? rnd6() : fns[$urandom_range(0, 5)];
            runInstruction(op, fn, $urandom_range(0, 2), $urandom_range(0, 3),
                           rnd1(), $urandom_range(1, 4), ($urandom_range(0, 15) == 0));
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
